instr_queue_multi: RTL and testbench

Parametrised fetch/dispatch instruction queue for the Tomasulo core. Issues single-outstanding reads to instruction memory, buffers returned instructions with their PCs in a circular queue of DEPTH entries, and dispatches the head in order to the ROB plus one of NUM_RS reservation stations chosen by opcode class. Supports a branch-mispredict flush with fetch redirect, including discard of an in-flight read.

---
 rtl/instr_queue_multi_pkg.sv | 34 +++
 rtl/instr_queue_multi_fifo.sv | 44 ++++
 rtl/instr_queue_multi.sv | 123 ++++++++++++
 tb/tb_instr_queue_multi.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_multi_pkg.sv
// Shared types for the fetch/dispatch instruction queue: queue entry layout,
// RV32I opcodes, reservation-station classes and fetch FSM states.
package instr_queue_multi_pkg;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } rv32i_opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  typedef enum logic {RS_ALU, RS_BR} rs_class_e;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_e;

  // Control-flow instructions all go to the dedicated branch station.
  function automatic rs_class_e to_rs_class(input logic [6:0] opcode);
    case (opcode)
      OP_BR, OP_JAL, OP_JALR: return RS_BR;
      default:                return RS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/instr_queue_multi_fifo.sv
// Circular buffer of queue entries with synchronous clear; head is always the
// oldest entry and count tracks occupancy including simultaneous push/pop.
module iq_fifo
  import instr_queue_multi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  iq_entry_t                  push_data,
  input  logic                       pop,
  output iq_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  iq_entry_t     mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/instr_queue_multi.sv
// Fetch/dispatch instruction queue: single-outstanding fetch FSM feeding an
// in-order queue whose head dispatches to the ROB and one reservation station.
module instr_queue_multi
  import instr_queue_multi_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          NUM_RS   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  input  logic                       instr_mem_resp,
  input  logic [31:0]                instr_mem_rdata,
  output logic                       instr_read,
  output logic [31:0]                instr_mem_address,
  input  logic                       rob_full,
  input  logic [NUM_RS-1:0]          rs_empty,
  output logic                       rob_load,
  output logic [NUM_RS-1:0]          rs_load,
  output logic [31:0]                disp_instr,
  output logic [31:0]                disp_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int             CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  fetch_state_e      state, state_next;
  logic [31:0]       fetch_pc;
  logic [31:0]       drain_pc;
  iq_entry_t         head;
  iq_entry_t         push_data;
  logic              push;
  logic              pop;
  logic              empty;
  logic [CW-1:0]     next_count;
  rs_class_e         head_class;
  logic [NUM_RS-1:0] target;

  // Responses are only kept while in FETCH; a draining or flushed read is dropped.
  assign push       = !rst && !flush && (state == FETCH) && instr_mem_resp;
  assign push_data  = '{pc: fetch_pc, instr: instr_mem_rdata};
  assign empty      = (count == '0);
  assign next_count = count + CW'(push) - CW'(pop);

  iq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    head_class = to_rs_class(head.instr[6:0]);
    target     = '0;
    if (head_class == RS_BR) begin
      target[NUM_RS-1] = rs_empty[NUM_RS-1];
    end else begin
      for (int i = NUM_RS-2; i >= 0; i--) begin
        if (rs_empty[i]) begin
          target    = '0;
          target[i] = 1'b1;
        end
      end
    end
    pop        = !rst && !empty && !rob_full && !flush && (target != '0);
    rob_load   = pop;
    rs_load    = pop ? target : '0;
    disp_instr = empty ? '0 : head.instr;
    disp_pc    = empty ? '0 : head.pc;
  end

  // A read is outstanding whenever instr_read is high, so a flush without a
  // coincident response must drain it at the old address before redirecting.
  always_comb begin
    state_next        = state;
    instr_read        = 1'b0;
    instr_mem_address = fetch_pc;
    case (state)
      FETCH: begin
        instr_read = 1'b1;
        if (instr_mem_resp && next_count == FULL) state_next = HOLD;
      end
      HOLD: begin
        if (count < FULL) state_next = FETCH;
      end
      DRAIN: begin
        instr_read        = 1'b1;
        instr_mem_address = drain_pc;
        if (instr_mem_resp) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (flush) begin
      if (state == HOLD || instr_mem_resp) state_next = FETCH;
      else                                 state_next = DRAIN;
    end
    if (rst) instr_read = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      drain_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (flush) begin
        fetch_pc <= flush_pc;
        if (state == FETCH) drain_pc <= fetch_pc;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instr_queue_multi.sv
// Directed bench for instr_queue_multi with a small latency-programmable
// instruction memory whose words encode their own address.
module tb_instr_queue_multi;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        resp;
  logic [31:0] rdata;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        rob_full;
  logic [4:0]  rs_empty;
  logic        rob_load;
  logic [4:0]  rs_load;
  logic [31:0] disp_instr;
  logic [31:0] disp_pc;
  logic [3:0]  count;

  int tests_run;
  int tests_failed;

  logic        pending;
  int          lat_left;
  int          mem_lat;
  logic [31:0] pend_addr;
  logic        snap_req;
  logic        snap_resp;
  logic [31:0] snap_addr;
  logic [6:0]  op60;
  logic [6:0]  op64;

  instr_queue_multi #(.DEPTH(8), .NUM_RS(5), .RESET_PC(32'h0000_0060)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .instr_mem_resp    (resp),
    .instr_mem_rdata   (rdata),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .rob_full          (rob_full),
    .rs_empty          (rs_empty),
    .rob_load          (rob_load),
    .rs_load           (rs_load),
    .disp_instr        (disp_instr),
    .disp_pc           (disp_pc),
    .count             (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [6:0] op;
    op = (a == 32'h60) ? op60 : (a == 32'h64) ? op64 : 7'h13;
    return {a[24:0], op};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One clock: sample the request before the edge, then update the memory model.
  task automatic applyStimulus();
    @(negedge clk);
    snap_req  = instr_read;
    snap_addr = instr_mem_address;
    snap_resp = resp;
    @(posedge clk);
    #1;
    resp  = 1'b0;
    rdata = '0;
    if (!pending && snap_req === 1'b1 && !snap_resp) begin
      pending   = 1'b1;
      lat_left  = mem_lat;
      pend_addr = snap_addr;
    end
    if (pending) begin
      lat_left--;
      if (lat_left == 0) begin
        pending = 1'b0;
        resp    = 1'b1;
        rdata   = imem(pend_addr);
      end
    end
    #2;
  endtask

  task automatic applyReset();
    rst     = 1'b1;
    flush   = 1'b0;
    pending = 1'b0;
    resp    = 1'b0;
    rdata   = '0;
    mem_lat = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("read_in_reset", 32'(instr_read), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic waitCount(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (count == 4'(target)) break;
      applyStimulus();
    end
    checkOutput("wait_count", 32'(count), 32'(target));
  endtask

  initial begin
    int          n;
    logic [31:0] exp_pc;
    logic        seen;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    flush_pc     = '0;
    resp         = 1'b0;
    rdata        = '0;
    rob_full     = 1'b0;
    rs_empty     = 5'b11111;
    pending      = 1'b0;
    lat_left     = 0;
    mem_lat      = 1;
    pend_addr    = '0;
    op60         = 7'h13;
    op64         = 7'h13;

    // Reset values and three single-cycle ADDI fetches
    applyReset();
    checkOutput("rst_read", 32'(instr_read), 32'd1);
    checkOutput("rst_addr", instr_mem_address, 32'h60);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_robload", 32'(rob_load), 32'd0);
    checkOutput("rst_rsload", 32'(rs_load), 32'd0);
    checkOutput("rst_dinstr", disp_instr, 32'd0);
    checkOutput("rst_dpc", disp_pc, 32'd0);
    applyStimulus();
    checkOutput("c1_nobypass", 32'(rob_load), 32'd0);
    applyStimulus();
    checkOutput("c2_robload", 32'(rob_load), 32'd1);
    checkOutput("c2_rsload", 32'(rs_load), 32'h01);
    checkOutput("c2_dpc", disp_pc, 32'h60);
    checkOutput("c2_dinstr", disp_instr, 32'h0000_3013);
    checkOutput("c2_addr", instr_mem_address, 32'h64);
    applyStimulus();
    checkOutput("c3_robload", 32'(rob_load), 32'd0);
    applyStimulus();
    checkOutput("c4_dpc", disp_pc, 32'h64);
    checkOutput("c4_rsload", 32'(rs_load), 32'h01);
    applyStimulus();
    applyStimulus();
    checkOutput("c6_dpc", disp_pc, 32'h68);
    checkOutput("c6_rsload", 32'(rs_load), 32'h01);
    checkOutput("c6_addr", instr_mem_address, 32'h6c);

    // Saturation with ROB full, then in-order drain and fetch resume
    rob_full = 1'b1;
    applyReset();
    waitCount(8, 40);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("sat_count", 32'(count), 32'd8);
    checkOutput("sat_read", 32'(instr_read), 32'd0);
    checkOutput("sat_robload", 32'(rob_load), 32'd0);
    checkOutput("sat_head", disp_pc, 32'h60);
    rob_full = 1'b0;
    exp_pc   = 32'h60;
    n        = 0;
    seen     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (rob_load) begin
        checkOutput("drain_pc", disp_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      if (instr_read && !seen) begin
        checkOutput("resume_addr", instr_mem_address, 32'h80);
        seen = 1'b1;
      end
      if (n == 10) break;
      applyStimulus();
    end
    checkOutput("drain_n", 32'(n), 32'd10);

    // Station selection by opcode class
    op60     = 7'h63;
    op64     = 7'h33;
    rs_empty = 5'b01111;
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("br_count", 32'(count), 32'd3);
    checkOutput("br_blocked", 32'(rob_load), 32'd0);
    checkOutput("br_blk_rs", 32'(rs_load), 32'd0);
    checkOutput("br_head", disp_pc, 32'h60);
    rs_empty = 5'b11111;
    #1;
    checkOutput("br_robload", 32'(rob_load), 32'd1);
    checkOutput("br_rsload", 32'(rs_load), 32'h10);
    applyStimulus();
    rs_empty = 5'b11100;
    #1;
    checkOutput("alu_dpc", disp_pc, 32'h64);
    checkOutput("alu_rsload", 32'(rs_load), 32'h04);
    applyStimulus();
    rs_empty = 5'b10000;
    #1;
    checkOutput("alu_nofree", 32'(rob_load), 32'd0);
    rs_empty = 5'b11111;
    rob_full = 1'b1;
    #1;
    checkOutput("robfull_rs", 32'(rs_load), 32'd0);
    op60 = 7'h13;
    op64 = 7'h13;

    // Flush with a slow outstanding read to 0x70
    rob_full = 1'b1;
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus();
    checkOutput("fl_addr70", instr_mem_address, 32'h70);
    checkOutput("fl_count4", 32'(count), 32'd4);
    mem_lat = 4;
    applyStimulus();
    flush    = 1'b1;
    flush_pc = 32'h200;
    rob_full = 1'b0;
    #1;
    checkOutput("fl_suppress", 32'(rob_load), 32'd0);
    applyStimulus();
    flush   = 1'b0;
    mem_lat = 1;
    #1;
    checkOutput("fl_count0", 32'(count), 32'd0);
    checkOutput("fl_drain_addr", instr_mem_address, 32'h70);
    checkOutput("fl_drain_read", 32'(instr_read), 32'd1);
    checkOutput("fl_dpc_mask", disp_pc, 32'd0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("fl_redirect", instr_mem_address, 32'h200);
    checkOutput("fl_discard", 32'(count), 32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("fl_disp", 32'(rob_load), 32'd1);
    checkOutput("fl_disp_pc", disp_pc, 32'h200);

    // Flush coinciding with a response
    rob_full = 1'b1;
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus();
    rob_full = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h200;
    #1;
    checkOutput("fr_robload", 32'(rob_load), 32'd0);
    checkOutput("fr_rsload", 32'(rs_load), 32'd0);
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("fr_count", 32'(count), 32'd0);
    checkOutput("fr_addr", instr_mem_address, 32'h200);
    checkOutput("fr_read", 32'(instr_read), 32'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("fr_disp_pc", disp_pc, 32'h200);

    // Near-full steady state: push and pop together across pointer wrap
    rob_full = 1'b1;
    applyReset();
    waitCount(8, 40);
    rob_full = 1'b0;
    #1;
    checkOutput("wr_first", disp_pc, 32'h60);
    applyStimulus();
    exp_pc = 32'h64;
    n      = 0;
    for (int i = 0; i < 30; i++) begin
      rob_full = !resp;
      #1;
      if (rob_load) begin
        checkOutput("wr_pc", disp_pc, exp_pc);
        checkOutput("wr_count", 32'(count), 32'd7);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      applyStimulus();
    end
    checkOutput("wr_n", 32'(n), 32'd14);
    rob_full = 1'b1;
    #1;
    applyStimulus();
    checkOutput("wr_full", 32'(count), 32'd8);
    checkOutput("wr_hold", 32'(instr_read), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
